// File: rtl/pipelined_cla_adder_if.sv
// Operand/result stream bundle for pipelined_cla_adder: operands in, sum/flags out,
// each direction with its own valid/ready pair.
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// Pipelined block CLA adder/subtractor: one BLK-bit look-ahead group per stage, NBLK-cycle latency,
// whole pipe freezes (bubbles included) while the result is stalled. PIPELINED_CLA_SAT_EN adds signed saturation.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLK   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  pipelined_cla_adder_if.slave  bus
);
  localparam int NBLK = WIDTH / BLK;
  localparam int L    = NBLK - 1;

  if (WIDTH < 2) begin : g_chk_width
    $error("pipelined_cla_adder: WIDTH must be at least 2");
  end
  if (WIDTH % BLK != 0) begin : g_chk_blk
    $error("pipelined_cla_adder: WIDTH must be a multiple of BLK");
  end

  // Returns {carry_out, sum} of one group; internal carries and the group G/P are
  // all expanded as sum-of-products so no carry ripples inside the group.
  function automatic logic [BLK:0] cla_group(
    input logic [BLK-1:0] x,
    input logic [BLK-1:0] y,
    input logic           ci
  );
    logic [BLK-1:0] g;
    logic [BLK-1:0] p;
    logic [BLK-1:0] c;
    logic           term;
    logic           grp_g;
    logic           grp_p;
    g = x & y;
    p = x ^ y;
    c = '0;
    c[0] = ci;
    for (int i = 1; i < BLK; i++) begin
      term = ci;
      for (int m = 0; m < i; m++) term = term & p[m];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    grp_p = &p;
    grp_g = 1'b0;
    for (int j = 0; j < BLK; j++) begin
      term = g[j];
      for (int m = j + 1; m < BLK; m++) term = term & p[m];
      grp_g = grp_g | term;
    end
    return {grp_g | (grp_p & ci), p ^ c};
  endfunction

  logic             adv;
  logic             fin_vld;
  logic [WIDTH-1:0] fin_sum;
  logic             fin_cout;
  logic             fin_ovf;

  assign adv           = !fin_vld || bus.out_ready;
  assign bus.in_ready  = adv;
  assign bus.out_valid = fin_vld;
  assign bus.sum       = fin_sum;
  assign bus.cout      = fin_cout;
  assign bus.ovf       = fin_ovf;

  // Stage k sees x_i = {a bits not yet consumed, sum bits already resolved} and
  // y_i = effective-b bits not yet consumed; group k sits at the bottom of y_i.
  for (genvar k = 0; k < NBLK; k++) begin : g_stg
    localparam int RW = WIDTH - k * BLK;

    logic             vld_i;
    logic             c_i;
    logic [WIDTH-1:0] x_i;
    logic [RW-1:0]    y_i;
    logic [BLK:0]     grp;
    logic [WIDTH-1:0] x_o;

    assign grp = cla_group(x_i[k*BLK +: BLK], y_i[BLK-1:0], c_i);

    always_comb begin
      x_o = x_i;
      x_o[k*BLK +: BLK] = grp[BLK-1:0];
    end

    if (k == 0) begin : g_head
      assign vld_i = bus.in_valid;
      assign c_i   = bus.sub | bus.cin;
      assign x_i   = bus.a;
      assign y_i   = bus.sub ? ~bus.b : bus.b;
    end else begin : g_body
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_i <= 1'b0;
          c_i   <= 1'b0;
          x_i   <= '0;
          y_i   <= '0;
        end else if (adv) begin
          vld_i <= g_stg[k-1].vld_i;
          c_i   <= g_stg[k-1].grp[BLK];
          x_i   <= g_stg[k-1].x_o;
          y_i   <= g_stg[k-1].y_i[WIDTH-(k-1)*BLK-1:BLK];
        end
      end
    end
  end

  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] fin_sum_d;
  logic             a_msb;
  logic             b_msb;
  logic             ovf_d;

  assign raw_sum = g_stg[L].x_o;
  assign a_msb   = g_stg[L].x_i[WIDTH-1];
  assign b_msb   = g_stg[L].y_i[BLK-1];
  assign ovf_d   = (a_msb == b_msb) && (raw_sum[WIDTH-1] != a_msb);

`ifdef PIPELINED_CLA_SAT_EN
  // Clamp toward the sign of a; cout/ovf still describe the wrapped result.
  assign fin_sum_d = ovf_d ? {a_msb, {(WIDTH-1){!a_msb}}} : raw_sum;
`else
  assign fin_sum_d = raw_sum;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fin_vld  <= 1'b0;
      fin_sum  <= '0;
      fin_cout <= 1'b0;
      fin_ovf  <= 1'b0;
    end else if (adv) begin
      fin_vld  <= g_stg[L].vld_i;
      fin_sum  <= fin_sum_d;
      fin_cout <= g_stg[L].grp[BLK];
      fin_ovf  <= ovf_d;
    end
  end

  a_out_hold: assert property (@(posedge clk) disable iff (!rst_n)
    (fin_vld && !bus.out_ready) |=> (fin_vld && $stable(fin_sum) && $stable(fin_cout) && $stable(fin_ovf)));
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// Scoreboard bench for pipelined_cla_adder: directed cases on 16/4, random streams on 16/4, 32/8 and 8/8.
module tb_pipelined_cla_adder;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  pipelined_cla_adder_if #(.WIDTH(16)) bus16 ();
  pipelined_cla_adder_if #(.WIDTH(32)) bus32 ();
  pipelined_cla_adder_if #(.WIDTH(8))  bus8  ();

  pipelined_cla_adder #(.WIDTH(16), .BLK(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16));
  pipelined_cla_adder #(.WIDTH(32), .BLK(8)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));
  pipelined_cla_adder #(.WIDTH(8),  .BLK(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));

  typedef struct packed { logic co; logic ov; logic [63:0] s; } res_t;
  typedef struct packed { logic acc; logic fire; logic rdy; logic vld; res_t r; } smp_t;

  int   n_vec  = 0;
  int   n_miss = 0;
  res_t q16[$];
  res_t q32[$];
  res_t q8[$];

  function automatic res_t model(int w, logic [63:0] a, logic [63:0] b, logic cin, logic sub);
    logic [63:0] mask;
    logic [63:0] beff;
    logic [64:0] full;
    res_t        r;
    mask = (64'd1 << w) - 64'd1;
    beff = (sub ? ~b : b) & mask;
    full = {1'b0, a & mask} + {1'b0, beff} + 65'(sub ? 1'b1 : cin);
    r.s  = full[63:0] & mask;
    r.co = full[w];
    r.ov = (a[w-1] == beff[w-1]) && (r.s[w-1] != a[w-1]);
`ifdef PIPELINED_CLA_SAT_EN
    if (r.ov) r.s = a[w-1] ? (64'd1 << (w-1)) : (mask >> 1);
`endif
    return r;
  endfunction

  task automatic cyc16(output smp_t sm);
    @(negedge clk);
    sm.acc  = bus16.in_valid && bus16.in_ready;
    sm.fire = bus16.out_valid && bus16.out_ready;
    sm.rdy  = bus16.in_ready;
    sm.vld  = bus16.out_valid;
    sm.r.co = bus16.cout;
    sm.r.ov = bus16.ovf;
    sm.r.s  = 64'(bus16.sum);
    @(posedge clk);
    #1;
  endtask

  task automatic run_one(input logic [15:0] a, input logic [15:0] b, input logic cin, input logic sub,
                         output res_t r, output int lat);
    smp_t sm;
    lat = -1;
    r   = '0;
    bus16.a = a; bus16.b = b; bus16.cin = cin; bus16.sub = sub;
    bus16.in_valid = 1'b1; bus16.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc16(sm);
      if (sm.acc) break;
    end
    bus16.in_valid = 1'b0;
    if (!sm.acc) return;
    for (int i = 1; i <= 20; i++) begin
      cyc16(sm);
      if (sm.fire) begin
        r   = sm.r;
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    smp_t sm;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_vec++; if (bus16.out_valid !== 1'b0) begin n_miss++; $display("FAIL reset_out_valid: got %b want 0", bus16.out_valid); end
    n_vec++; if (bus16.sum !== 16'h0) begin n_miss++; $display("FAIL reset_sum: got %h want 0000", bus16.sum); end
    n_vec++; if (bus16.cout !== 1'b0) begin n_miss++; $display("FAIL reset_cout: got %b want 0", bus16.cout); end
    n_vec++; if (bus16.ovf !== 1'b0) begin n_miss++; $display("FAIL reset_ovf: got %b want 0", bus16.ovf); end
    n_vec++; if (bus32.out_valid !== 1'b0 || bus8.out_valid !== 1'b0) begin
      n_miss++; $display("FAIL reset_out_valid_w32_w8: got %b/%b want 0/0", bus32.out_valid, bus8.out_valid);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    cyc16(sm);
    n_vec++; if (sm.rdy !== 1'b1) begin n_miss++; $display("FAIL post_reset_in_ready: got %b want 1", sm.rdy); end
    n_vec++; if (sm.vld !== 1'b0) begin n_miss++; $display("FAIL post_reset_out_valid: got %b want 0", sm.vld); end
  endtask

  task automatic test_add();
    res_t r;
    int   lat;
    run_one(16'hFFFF, 16'h0001, 1'b0, 1'b0, r, lat);
    n_vec++; if (lat !== 4) begin n_miss++; $display("FAIL add_latency: got %0d want 4", lat); end
    n_vec++; if (r.s !== 64'h0 || r.co !== 1'b1 || r.ov !== 1'b0) begin
      n_miss++; $display("FAIL add_wrap: got sum=%h cout=%b ovf=%b want sum=0000 cout=1 ovf=0", r.s[15:0], r.co, r.ov);
    end
    run_one(16'hFFFF, 16'hFFFF, 1'b1, 1'b0, r, lat);
    n_vec++; if (r.s !== 64'hFFFF || r.co !== 1'b1 || r.ov !== 1'b0 || lat !== 4) begin
      n_miss++; $display("FAIL add_all_ones: got sum=%h cout=%b ovf=%b lat=%0d want sum=ffff cout=1 ovf=0 lat=4", r.s[15:0], r.co, r.ov, lat);
    end
  endtask

  task automatic test_sub();
    res_t r;
    int   lat;
    run_one(16'h0005, 16'h0007, 1'b1, 1'b1, r, lat);
    n_vec++; if (r.s !== 64'hFFFE || r.co !== 1'b0 || r.ov !== 1'b0 || lat !== 4) begin
      n_miss++; $display("FAIL sub_borrow: got sum=%h cout=%b ovf=%b lat=%0d want sum=fffe cout=0 ovf=0 lat=4", r.s[15:0], r.co, r.ov, lat);
    end
    run_one(16'h0007, 16'h0005, 1'b0, 1'b1, r, lat);
    n_vec++; if (r.s !== 64'h0002 || r.co !== 1'b1 || r.ov !== 1'b0) begin
      n_miss++; $display("FAIL sub_no_borrow: got sum=%h cout=%b ovf=%b want sum=0002 cout=1 ovf=0", r.s[15:0], r.co, r.ov);
    end
  endtask

  task automatic test_overflow();
    res_t        r;
    int          lat;
    logic [15:0] exp_pos;
    logic [15:0] exp_neg;
`ifdef PIPELINED_CLA_SAT_EN
    exp_pos = 16'h7FFF;
    exp_neg = 16'h8000;
`else
    exp_pos = 16'h8000;
    exp_neg = 16'h7FFF;
`endif
    run_one(16'h7FFF, 16'h0001, 1'b0, 1'b0, r, lat);
    n_vec++; if (r.s !== 64'(exp_pos) || r.co !== 1'b0 || r.ov !== 1'b1) begin
      n_miss++; $display("FAIL ovf_pos: got sum=%h cout=%b ovf=%b want sum=%h cout=0 ovf=1", r.s[15:0], r.co, r.ov, exp_pos);
    end
    run_one(16'h8000, 16'h0001, 1'b0, 1'b1, r, lat);
    n_vec++; if (r.s !== 64'(exp_neg) || r.co !== 1'b1 || r.ov !== 1'b1) begin
      n_miss++; $display("FAIL ovf_neg: got sum=%h cout=%b ovf=%b want sum=%h cout=1 ovf=1", r.s[15:0], r.co, r.ov, exp_neg);
    end
  endtask

  task automatic test_back_to_back();
    smp_t        sm;
    res_t        e;
    int          nsent = 0;
    int          nrecv = 0;
    int          hold = 0;
    int          hold_cycles = 0;
    int          extra = 0;
    bit          seen = 0;
    bit          gap = 0;
    logic [15:0] held_sum = '0;
    q16.delete();
    for (int c = 0; c < 40 && nrecv < 8; c++) begin
      if (nsent < 8) begin
        bus16.in_valid = 1'b1;
        bus16.a = 16'(nsent + 1);
        bus16.b = 16'((nsent + 1) * 16'h1000);
        bus16.cin = 1'b0; bus16.sub = 1'b0;
      end else begin
        bus16.in_valid = 1'b0;
      end
      if (!seen && bus16.out_valid) begin
        seen = 1; hold = 3; held_sum = bus16.sum;
      end
      bus16.out_ready = (hold == 0);
      cyc16(sm);
      if (hold > 0) begin
        hold_cycles++;
        n_vec++; if (sm.rdy !== 1'b0) begin n_miss++; $display("FAIL stall_in_ready: got %b want 0", sm.rdy); end
        n_vec++; if (sm.vld !== 1'b1 || sm.r.s !== 64'(held_sum)) begin
          n_miss++; $display("FAIL stall_hold: got valid=%b sum=%h want valid=1 sum=%h", sm.vld, sm.r.s[15:0], held_sum);
        end
        hold--;
      end else if (seen && !sm.fire) begin
        gap = 1;
      end
      if (sm.acc) begin
        q16.push_back(model(16, 64'(bus16.a), 64'(bus16.b), bus16.cin, bus16.sub));
        nsent++;
      end
      if (sm.fire) begin
        nrecv++;
        n_vec++;
        if (q16.size() == 0) begin
          n_miss++; $display("FAIL b2b_order: got sum=%h with no outstanding transaction", sm.r.s[15:0]);
        end else begin
          e = q16.pop_front();
          if (sm.r !== e) begin
            n_miss++; $display("FAIL b2b_order: got sum=%h cout=%b ovf=%b want sum=%h cout=%b ovf=%b",
                               sm.r.s[15:0], sm.r.co, sm.r.ov, e.s[15:0], e.co, e.ov);
          end
        end
      end
    end
    bus16.in_valid = 1'b0;
    bus16.out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc16(sm);
      if (sm.vld) extra++;
    end
    n_vec++; if (nrecv !== 8 || nsent !== 8) begin n_miss++; $display("FAIL b2b_count: got sent=%0d recv=%0d want 8/8", nsent, nrecv); end
    n_vec++; if (hold_cycles !== 3) begin n_miss++; $display("FAIL b2b_hold_seen: got %0d stall cycles want 3", hold_cycles); end
    n_vec++; if (gap !== 1'b0) begin n_miss++; $display("FAIL b2b_throughput: got gap=%b want 0", gap); end
    n_vec++; if (extra !== 0) begin n_miss++; $display("FAIL b2b_duplicate: got %0d extra results want 0", extra); end
  endtask

  task automatic test_reset_midflight();
    smp_t sm;
    res_t r;
    int   lat;
    int   spurious = 0;
    bus16.out_ready = 1'b0;
    bus16.cin = 1'b0; bus16.sub = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus16.in_valid = 1'b1;
      bus16.a = 16'h7FFF;
      bus16.b = 16'(16'h7FFF - i);
      cyc16(sm);
    end
    bus16.in_valid = 1'b0;
    cyc16(sm);
    n_vec++; if (bus16.out_valid !== 1'b1) begin n_miss++; $display("FAIL midflight_pre_valid: got %b want 1", bus16.out_valid); end
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus16.out_valid !== 1'b0 || bus16.sum !== 16'h0 || bus16.cout !== 1'b0 || bus16.ovf !== 1'b0) begin
      n_miss++; $display("FAIL midflight_clear: got valid=%b sum=%h cout=%b ovf=%b want all 0",
                         bus16.out_valid, bus16.sum, bus16.cout, bus16.ovf);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus16.out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cyc16(sm);
      if (sm.vld) spurious++;
    end
    n_vec++; if (spurious !== 0) begin n_miss++; $display("FAIL midflight_stale: got %0d stale results want 0", spurious); end
    run_one(16'h1234, 16'h4321, 1'b1, 1'b0, r, lat);
    n_vec++; if (r.s !== 64'h5556 || r.co !== 1'b0 || r.ov !== 1'b0 || lat !== 4) begin
      n_miss++; $display("FAIL midflight_restart: got sum=%h cout=%b ovf=%b lat=%0d want sum=5556 cout=0 ovf=0 lat=4",
                         r.s[15:0], r.co, r.ov, lat);
    end
  endtask

  task automatic test_random();
    localparam int N = 10000;
    int          acc16 = 0;
    int          acc32 = 0;
    int          acc8 = 0;
    int          cyc = 0;
    res_t        e;
    res_t        got;
    logic        prev_stall = 1'b0;
    logic [15:0] prev_sum = '0;
    q16.delete(); q32.delete(); q8.delete();
    while ((acc16 < N || acc32 < N || acc8 < N || q16.size() > 0 || q32.size() > 0 || q8.size() > 0) && cyc < 60000) begin
      bus16.in_valid = (acc16 < N) && ($urandom_range(0, 3) != 0);
      bus16.a = 16'($urandom); bus16.b = 16'($urandom);
      bus16.cin = 1'($urandom); bus16.sub = 1'($urandom);
      bus16.out_ready = ($urandom_range(0, 3) != 0);
      bus32.in_valid = (acc32 < N) && ($urandom_range(0, 3) != 0);
      bus32.a = $urandom; bus32.b = $urandom;
      bus32.cin = 1'($urandom); bus32.sub = 1'($urandom);
      bus32.out_ready = ($urandom_range(0, 3) != 0);
      bus8.in_valid = (acc8 < N) && ($urandom_range(0, 3) != 0);
      bus8.a = 8'($urandom); bus8.b = 8'($urandom);
      bus8.cin = 1'($urandom); bus8.sub = 1'($urandom);
      bus8.out_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      if (prev_stall) begin
        n_vec++; if (bus16.out_valid !== 1'b1 || bus16.sum !== prev_sum) begin
          n_miss++; $display("FAIL rand_hold16: got valid=%b sum=%h want valid=1 sum=%h", bus16.out_valid, bus16.sum, prev_sum);
        end
      end
      prev_stall = bus16.out_valid && !bus16.out_ready;
      prev_sum = bus16.sum;
      if (bus16.in_valid && bus16.in_ready) begin
        q16.push_back(model(16, 64'(bus16.a), 64'(bus16.b), bus16.cin, bus16.sub)); acc16++;
      end
      if (bus16.out_valid && bus16.out_ready) begin
        got = '{bus16.cout, bus16.ovf, 64'(bus16.sum)};
        e = (q16.size() > 0) ? q16.pop_front() : '{1'bx, 1'bx, 64'bx};
        n_vec++; if (got !== e) begin
          n_miss++; $display("FAIL rand16: got cout=%b ovf=%b sum=%h want cout=%b ovf=%b sum=%h", got.co, got.ov, got.s[15:0], e.co, e.ov, e.s[15:0]);
        end
      end
      if (bus32.in_valid && bus32.in_ready) begin
        q32.push_back(model(32, 64'(bus32.a), 64'(bus32.b), bus32.cin, bus32.sub)); acc32++;
      end
      if (bus32.out_valid && bus32.out_ready) begin
        got = '{bus32.cout, bus32.ovf, 64'(bus32.sum)};
        e = (q32.size() > 0) ? q32.pop_front() : '{1'bx, 1'bx, 64'bx};
        n_vec++; if (got !== e) begin
          n_miss++; $display("FAIL rand32: got cout=%b ovf=%b sum=%h want cout=%b ovf=%b sum=%h", got.co, got.ov, got.s[31:0], e.co, e.ov, e.s[31:0]);
        end
      end
      if (bus8.in_valid && bus8.in_ready) begin
        q8.push_back(model(8, 64'(bus8.a), 64'(bus8.b), bus8.cin, bus8.sub)); acc8++;
      end
      if (bus8.out_valid && bus8.out_ready) begin
        got = '{bus8.cout, bus8.ovf, 64'(bus8.sum)};
        e = (q8.size() > 0) ? q8.pop_front() : '{1'bx, 1'bx, 64'bx};
        n_vec++; if (got !== e) begin
          n_miss++; $display("FAIL rand8: got cout=%b ovf=%b sum=%h want cout=%b ovf=%b sum=%h", got.co, got.ov, got.s[7:0], e.co, e.ov, e.s[7:0]);
        end
      end
      @(posedge clk); #1;
      cyc++;
    end
    bus16.in_valid = 1'b0; bus32.in_valid = 1'b0; bus8.in_valid = 1'b0;
    n_vec++; if (acc16 !== N || acc32 !== N || acc8 !== N) begin
      n_miss++; $display("FAIL rand_budget: got accepts %0d/%0d/%0d want %0d each", acc16, acc32, acc8, N);
    end
    n_vec++; if (q16.size() != 0 || q32.size() != 0 || q8.size() != 0) begin
      n_miss++; $display("FAIL rand_drain: got %0d/%0d/%0d outstanding want 0", q16.size(), q32.size(), q8.size());
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus16.in_valid = 1'b0; bus16.a = '0; bus16.b = '0; bus16.cin = 1'b0; bus16.sub = 1'b0; bus16.out_ready = 1'b1;
    bus32.in_valid = 1'b0; bus32.a = '0; bus32.b = '0; bus32.cin = 1'b0; bus32.sub = 1'b0; bus32.out_ready = 1'b1;
    bus8.in_valid  = 1'b0; bus8.a  = '0; bus8.b  = '0; bus8.cin  = 1'b0; bus8.sub  = 1'b0; bus8.out_ready  = 1'b1;
    test_reset();
    test_add();
    test_sub();
    test_overflow();
    test_back_to_back();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
